// File: rtl/mult_count_system_if.sv
// Observation bus for mult_count_system: count enable in, counter values,
// their sum and their product out.
interface mult_count_system_if #(
  parameter int WIDTH = 8
);
  logic                 CE;
  logic [WIDTH-1:0]     Q_1;
  logic [WIDTH-1:0]     Q_2;
  logic [WIDTH-1:0]     S;
  logic [2*WIDTH-1:0]   q;

  modport master (output CE, input Q_1, Q_2, S, q);
  modport slave  (input CE, output Q_1, Q_2, S, q);
endinterface

// File: rtl/mult_count_system.sv
// mult_count_system: two wrapping counters sharing one count enable, a
// combinational modular sum of the counters and an unsigned product of them.
// The product is registered (one cycle behind the counters) by default.
// Defining MULT_COMB_EN removes the product register and drives q
// combinationally from the counters with zero latency.
module mult_count_system #(
  parameter int WIDTH  = 8,
  parameter int STEP_1 = 1,
  parameter int STEP_2 = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  mult_count_system_if.slave   bus
);

  logic [WIDTH-1:0] cnt_1;
  logic [WIDTH-1:0] cnt_2;

  // Modular add: carry out of the top bit is dropped, giving silent wrap.
  function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    wrap_add = a + b;
  endfunction

  // Full-width unsigned product; 2*WIDTH bits always holds the result.
  function automatic logic [2*WIDTH-1:0] umul(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    umul = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  endfunction

  // Counter 1 advances by STEP_1 per enabled edge; reset wins over enable.
  always_ff @(posedge CLK) begin
    if (RST)
      cnt_1 <= '0;
    else if (bus.CE)
      cnt_1 <= wrap_add(cnt_1, WIDTH'(STEP_1));
  end

  // Counter 2 advances by STEP_2 per enabled edge; reset wins over enable.
  always_ff @(posedge CLK) begin
    if (RST)
      cnt_2 <= '0;
    else if (bus.CE)
      cnt_2 <= wrap_add(cnt_2, WIDTH'(STEP_2));
  end

  assign bus.Q_1 = cnt_1;
  assign bus.Q_2 = cnt_2;
  assign bus.S   = wrap_add(cnt_1, cnt_2);

`ifdef MULT_COMB_EN
  // Zero-latency product; reads zero during reset since both counters are zero.
  assign bus.q = umul(cnt_1, cnt_2);
`else
  logic [2*WIDTH-1:0] prod_p1;

  // Stage p1: product of the counter values seen before this edge, loaded
  // every non-reset edge regardless of CE so it catches up when counting stops.
  always_ff @(posedge CLK) begin
    if (RST)
      prod_p1 <= '0;
    else
      prod_p1 <= umul(cnt_1, cnt_2);
  end

  assign bus.q = prod_p1;
`endif

endmodule

// File: tb/tb_mult_count_system.sv
// Scoreboard bench for mult_count_system: a driver applies directed
// segments of RST/CE and queues the hand-computed outputs expected after
// each segment; a monitor on the falling edge pops and compares them.
module tb_mult_count_system;

  logic CLK;
  logic RST;

  mult_count_system_if #(.WIDTH(8)) bus ();

  mult_count_system #(.WIDTH(8), .STEP_1(1), .STEP_2(2)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [7:0]  q1;
    logic [7:0]  q2;
    logic [7:0]  s;
    logic [15:0] q;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compare every queued expectation against the settled outputs.
  always @(negedge CLK) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp({e.name, ".Q_1"}, {8'h00, bus.Q_1}, {8'h00, e.q1});
      cmp({e.name, ".Q_2"}, {8'h00, bus.Q_2}, {8'h00, e.q2});
      cmp({e.name, ".S"},   {8'h00, bus.S},   {8'h00, e.s});
      cmp({e.name, ".q"},   bus.q,            e.q);
    end
  end

  // Apply RST/CE for n edges, then queue the outputs expected afterwards.
  // q_reg is the registered-product expectation; the combinational build
  // expects the product of the current counter values instead.
  task automatic seg(input string name, input logic rst, input logic ce, input int n,
                     input logic [7:0] q1, input logic [7:0] q2, input logic [7:0] s,
                     input logic [15:0] q_reg);
    exp_t e;
    RST    = rst;
    bus.CE = ce;
    repeat (n) @(posedge CLK);
    #1;
    e.name = name;
    e.q1   = q1;
    e.q2   = q2;
    e.s    = s;
`ifdef MULT_COMB_EN
    e.q    = 16'(q1) * 16'(q2);
`else
    e.q    = q_reg;
`endif
    sb.push_back(e);
  endtask

  initial begin
    RST    = 1'b1;
    bus.CE = 1'b1;
    @(negedge CLK);

    // Reset held with CE high
    seg("reset2",      1, 1,   2, 8'h00, 8'h00, 8'h00, 16'h0000);
    // Basic count and hold
    seg("count3",      0, 1,   3, 8'h03, 8'h06, 8'h09, 16'd8);
    seg("hold1",       0, 0,   1, 8'h03, 8'h06, 8'h09, 16'd18);
    seg("hold2",       0, 0,   1, 8'h03, 8'h06, 8'h09, 16'd18);
    seg("rst_ce",      1, 1,   1, 8'h00, 8'h00, 8'h00, 16'h0000);
    // Enable gating
    seg("gate10",      0, 0,  10, 8'h00, 8'h00, 8'h00, 16'h0000);
    // Wrap and sum overflow over 200 counts
    seg("rst_a",       1, 0,   1, 8'h00, 8'h00, 8'h00, 16'h0000);
    seg("count200",    0, 1, 200, 8'hC8, 8'h90, 8'h58, 16'h6E62);
    seg("catchup200",  0, 0,   1, 8'hC8, 8'h90, 8'h58, 16'h7080);
    // Full counter wrap, inspecting Q_2 across 0xFE -> 0x00
    seg("rst_b",       1, 0,   1, 8'h00, 8'h00, 8'h00, 16'h0000);
    seg("count127",    0, 1, 127, 8'h7F, 8'hFE, 8'h7D, 16'h7C08);
    seg("count128",    0, 1,   1, 8'h80, 8'h00, 8'h80, 16'h7E02);
    seg("count256",    0, 1, 128, 8'h00, 8'h00, 8'h00, 16'hFD02);
    // Reset in the middle of counting
    seg("rst_c",       1, 0,   1, 8'h00, 8'h00, 8'h00, 16'h0000);
    seg("count50",     0, 1,  50, 8'h32, 8'h64, 8'h96, 16'h12C2);
    seg("midrst",      1, 1,   1, 8'h00, 8'h00, 8'h00, 16'h0000);
    seg("resume1",     0, 1,   1, 8'h01, 8'h02, 8'h03, 16'h0000);
    seg("resume2",     0, 1,   1, 8'h02, 8'h04, 8'h06, 16'd2);
    // CE toggling every cycle
    seg("tog_off",     0, 0,   1, 8'h02, 8'h04, 8'h06, 16'd8);
    seg("tog_on",      0, 1,   1, 8'h03, 8'h06, 8'h09, 16'd8);
    seg("tog_off2",    0, 0,   1, 8'h03, 8'h06, 8'h09, 16'd18);

    @(negedge CLK);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
